// File: rtl/lcd_display_ctrl.sv
// HD44780 character-LCD controller (8-bit bus, write-only): power-up init, then
// shows an opcode mnemonic on line 1 and the signed 16-bit result on line 2.
module lcd_display_ctrl #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned EN_CYCLES      = 12,
    parameter int unsigned WAIT_CYCLES    = 2500,
    parameter int unsigned CLR_WAIT       = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] result,
    output logic        ready,
    output logic        done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);
    localparam logic [2:0] PWR_WAIT = 3'd0, INIT = 3'd1, IDLE = 3'd2, CONVERT = 3'd3, WRITE = 3'd4;
    localparam logic [1:0] SETUP = 2'd0, EN_HI = 2'd1, HOLD = 2'd2;

    // One shared counter, reloaded per phase; 16 covers the conversion steps.
    localparam int unsigned MAX_A   = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
    localparam int unsigned MAX_B   = (WAIT_CYCLES > CLR_WAIT) ? WAIT_CYCLES : CLR_WAIT;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > 16) ? MAX_C : 16;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]       state;
    logic [1:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       byte_idx;
    logic [2:0]       op_q;
    logic             sign_q;
    logic [15:0]      bin_q;
    logic [19:0]      bcd_q;

    logic [3:0]       next_idx;
    logic [8:0]       next_byte;
    logic             is_last;
    logic [CNT_W-1:0] hold_last;
    logic [19:0]      dd_bcd;
    logic [15:0]      magnitude;

    function automatic logic [8:0] init_byte(input logic [3:0] idx);
        logic [8:0] b;
        case (idx)
            4'd0:    b = 9'h038;
            4'd1:    b = 9'h00C;
            4'd2:    b = 9'h006;
            default: b = 9'h001;
        endcase
        return b;
    endfunction

    // Returns {rs, data} for byte idx of the 13-byte display sequence.
    function automatic logic [8:0] write_byte(input logic [3:0] idx, input logic [2:0] op,
                                              input logic neg, input logic [19:0] bcd);
        logic [31:0] mn;
        logic [8:0]  b;
        case (op)
            3'd0:    mn = "LOAD";
            3'd1:    mn = "ADD ";
            3'd2:    mn = "ADDI";
            3'd3:    mn = "SUB ";
            3'd4:    mn = "SUBI";
            3'd5:    mn = "MUL ";
            3'd6:    mn = "CLR ";
            default: mn = "DPL ";
        endcase
        case (idx)
            4'd0:    b = {1'b0, 8'h01};
            4'd1:    b = {1'b0, 8'h80};
            4'd2:    b = {1'b1, mn[31:24]};
            4'd3:    b = {1'b1, mn[23:16]};
            4'd4:    b = {1'b1, mn[15:8]};
            4'd5:    b = {1'b1, mn[7:0]};
            4'd6:    b = {1'b0, 8'hC0};
            4'd7:    b = {1'b1, neg ? 8'h2D : 8'h2B};
            4'd8:    b = {1'b1, 4'h3, bcd[19:16]};
            4'd9:    b = {1'b1, 4'h3, bcd[15:12]};
            4'd10:   b = {1'b1, 4'h3, bcd[11:8]};
            4'd11:   b = {1'b1, 4'h3, bcd[7:4]};
            default: b = {1'b1, 4'h3, bcd[3:0]};
        endcase
        return b;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        next_idx  = byte_idx + 4'd1;
        next_byte = (state == INIT) ? init_byte(next_idx)
                                    : write_byte(next_idx, op_q, sign_q, bcd_q);
        is_last   = (state == INIT) ? (byte_idx == 4'd3) : (byte_idx == 4'd12);
        hold_last = (!lcd_rs && lcd_data == 8'h01) ? CNT_W'(CLR_WAIT - 1) : CNT_W'(WAIT_CYCLES - 1);
        magnitude = result[15] ? (~result + 16'd1) : result;
        dd_bcd    = bcd_q;
        for (int d = 0; d < 5; d++) begin
            if (dd_bcd[4*d +: 4] >= 4'd5) dd_bcd[4*d +: 4] = dd_bcd[4*d +: 4] + 4'd3;
        end
    end

    assign ready  = (state == IDLE);
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PWR_WAIT;
            phase    <= SETUP;
            cnt      <= '0;
            byte_idx <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                        state              <= INIT;
                        phase              <= SETUP;
                        cnt                <= '0;
                        byte_idx           <= '0;
                        {lcd_rs, lcd_data} <= init_byte(4'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        op_q   <= opcode;
                        sign_q <= result[15];
                        bin_q  <= magnitude;
                        bcd_q  <= '0;
                        cnt    <= '0;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {dd_bcd, bin_q} << 1;
                    if (cnt == CNT_W'(15)) begin
                        state              <= WRITE;
                        phase              <= SETUP;
                        cnt                <= '0;
                        byte_idx           <= '0;
                        {lcd_rs, lcd_data} <= write_byte(4'd0, op_q, sign_q, bcd_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT, WRITE: begin
                    case (phase)
                        SETUP: begin
                            lcd_en <= 1'b1;
                            phase  <= EN_HI;
                            cnt    <= '0;
                        end
                        EN_HI: begin
                            if (cnt == CNT_W'(EN_CYCLES - 1)) begin
                                lcd_en <= 1'b0;
                                phase  <= HOLD;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        HOLD: begin
                            if (cnt == hold_last) begin
                                cnt <= '0;
                                if (is_last) begin
                                    state <= IDLE;
                                    done  <= (state == WRITE);
                                end else begin
                                    byte_idx           <= next_idx;
                                    phase              <= SETUP;
                                    {lcd_rs, lcd_data} <= next_byte;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: phase <= SETUP;
                    endcase
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Bench for lcd_display_ctrl: cycle-level expected waveform built from byte
// lists and timing rules, compared every clock, plus literal text checks.
module tb_lcd_display_ctrl;
    localparam int PWR = 20, EN = 2, WT = 4, CLR = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  opcode = '0;
    logic [15:0] result = '0;
    logic        ready, done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_data;

    lcd_display_ctrl #(
        .POWERUP_CYCLES(PWR), .EN_CYCLES(EN), .WAIT_CYCLES(WT), .CLR_WAIT(CLR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .result(result),
        .ready(ready), .done(done), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       en;
        logic       rs;
        logic [7:0] data;
    } cyc_t;

    cyc_t       exp_q[$];
    cyc_t       exp_e;
    logic [8:0] mq[$];
    logic [8:0] cap_q[$];
    logic [8:0] model_last = '0;
    bit         model_on = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    string      mnem[8] = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d at %0t", name, act, lim, $time);
        end
    endtask

    function automatic cyc_t mk(input logic r, input logic d, input logic e, input logic [8:0] b);
        return {r, d, e, b};
    endfunction

    // Display text for one request, straight from the character rules.
    task automatic model_bytes(input logic [2:0] op, input logic [15:0] res);
        int    mag;
        string s;
        mq.delete();
        mag = res[15] ? 65536 - int'(res) : int'(res);
        s = mnem[op];
        mq.push_back(9'h001);
        mq.push_back(9'h080);
        for (int k = 0; k < 4; k++) mq.push_back({1'b1, s.getc(k)});
        mq.push_back(9'h0C0);
        mq.push_back({1'b1, res[15] ? 8'h2D : 8'h2B});
        for (int p = 10000; p >= 1; p = p / 10) mq.push_back({1'b1, 8'(32'h30 + (mag / p) % 10)});
    endtask

    task automatic push_byte(input logic [8:0] b);
        int hold;
        hold = (b == 9'h001) ? CLR : WT;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, b));
        for (int i = 0; i < EN; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, b));
        for (int i = 0; i < hold; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, b));
        model_last = b;
    endtask

    function automatic logic [127:0] pack_data(input bit use_model);
        logic [127:0] v;
        int n;
        v = '0;
        n = use_model ? mq.size() : cap_q.size();
        for (int i = 0; i < n; i++) v = {v[119:0], use_model ? mq[i][7:0] : cap_q[i][7:0]};
        return v;
    endfunction

    function automatic logic [15:0] pack_rs();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < cap_q.size(); i++) v = {v[14:0], cap_q[i][8]};
        return v;
    endfunction

    // Per-cycle compare against the expected waveform; idle is implied when empty.
    always @(negedge clk) begin
        check("rw_zero", 128'(lcd_rw), 128'(0));
        if (!rst_n) begin
            check("reset_outputs", 128'({ready, done, lcd_en, lcd_rs, lcd_data}), 128'(0));
        end else if (model_on) begin
            exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b1, 1'b0, 1'b0, model_last);
            check("cycle", 128'({ready, done, lcd_en, lcd_rs, lcd_data}), 128'(exp_e));
        end
    end

    // Bus-protocol monitor: stable data while en is high, enough en-low gap.
    logic       mon_prev_en = 1'b0;
    logic [8:0] mon_byte = '0;
    int         mon_gap = 0, mon_need = 0;
    bit         mon_have = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_en = 1'b0;
            mon_have    = 1'b0;
            mon_gap     = 0;
        end else begin
            if (lcd_en && !mon_prev_en) begin
                if (mon_have) check_ge("en_low_gap", mon_gap, mon_need);
                mon_byte = {lcd_rs, lcd_data};
                cap_q.push_back(mon_byte);
                mon_need = (mon_byte == 9'h001) ? CLR : WT;
                mon_have = 1'b1;
                mon_gap  = 0;
            end else if (lcd_en) begin
                check("en_stable", 128'({lcd_rs, lcd_data}), 128'(mon_byte));
            end else begin
                mon_gap++;
            end
            mon_prev_en = lcd_en;
        end
    end

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        cap_q.delete();
        model_last = '0;
        model_on = 1'b1;
        for (int i = 0; i < PWR; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 9'h000));
        push_byte(9'h038);
        push_byte(9'h00C);
        push_byte(9'h006);
        push_byte(9'h001);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (exp_q.size() != 0 && k < 3000);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: %0d cycles still expected after %0d clocks", exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] res, input bit disturb);
        int dly;
        wait_idle();
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, model_last));
        start = 1'b1;
        opcode = op;
        result = res;
        model_bytes(op, res);
        for (int i = 0; i < 16; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, model_last));
        foreach (mq[i]) push_byte(mq[i]);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, model_last));
        cap_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            dly = $urandom_range(20, 100);
            for (int i = 0; i < dly; i++) begin @(posedge clk); #1; end
            start = 1'b1;
            opcode = ~op;
            result = ~res;
            @(posedge clk); #1;
            start = 1'b0;
            result = 16'($urandom);
        end
    endtask

    task automatic check_init();
        check("init_bytes", pack_data(1'b0), 128'h38_0C_06_01);
        check("init_rs", 128'(pack_rs()), 128'(0));
        check("init_count", 128'(cap_q.size()), 128'(4));
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [15:0] res,
                            input bit disturb, input logic [127:0] lit);
        send(op, res, disturb);
        wait_idle();
        model_bytes(op, res);
        check({name, "_model"}, pack_data(1'b1), lit);
        check({name, "_lcd"}, pack_data(1'b0), lit);
        check({name, "_rs"}, 128'(pack_rs()), 128'(16'h07BF));
        check({name, "_count"}, 128'(cap_q.size()), 128'(13));
    endtask

    task automatic reset_mid_write(input logic [2:0] op, input logic [15:0] res);
        int k, dly;
        send(op, res, 1'b0);
        dly = $urandom_range(20, 90);
        for (int i = 0; i < dly; i++) begin @(posedge clk); #1; end
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (!lcd_en && k < 200);
        check("en_before_reset", 128'(lcd_en), 128'(1));
        rst_n = 1'b0;
        exp_q.delete();
        model_on = 1'b0;
        #1;
        check("reset_async", 128'({lcd_en, ready, done, lcd_rs, lcd_data}), 128'(0));
        repeat (3) @(posedge clk);
        release_reset();
        wait_idle();
        check_init();
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] edge_vals[4];
        edge_vals = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        repeat (3) @(posedge clk);
        release_reset();
        // A start while still powering up must be dropped.
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        opcode = 3'd5;
        result = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check_init();

        directed("add_7", 3'd1, 16'h0007, 1'b0, 128'h01_80_41_44_44_20_C0_2B_30_30_30_30_37);
        directed("sub_8000", 3'd3, 16'h8000, 1'b0, 128'h01_80_53_55_42_20_C0_2D_33_32_37_36_38);
        directed("clr_ffff", 3'd6, 16'hFFFF, 1'b0, 128'h01_80_43_4C_52_20_C0_2D_30_30_30_30_31);
        directed("addi_1234", 3'd2, 16'h1234, 1'b1, 128'h01_80_41_44_44_49_C0_2B_30_34_36_36_30);

        for (int t = 0; t < 14; t++) begin
            r = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            send(3'($urandom_range(0, 7)), r, 1'($urandom_range(0, 1)));
            wait_idle();
            check("rand_text", pack_data(1'b0), pack_data(1'b1));
        end

        reset_mid_write(3'd4, 16'h7FFF);
        reset_mid_write(3'($urandom_range(0, 7)), 16'($urandom));
        directed("load_after_reset", 3'd0, 16'h0000, 1'b0, 128'h01_80_4C_4F_41_44_C0_2B_30_30_30_30_30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_display_ctrl.md
LCD_DISPLAY_CTRL -- requirements
Module: lcd_display_ctrl

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input and rst_n input.
REQ-002 Parameters SHALL be defined as follows:
- POWERUP_CYCLES, 750000: wait after reset before the first init command.
- EN_CYCLES, 12: lcd_en high width in clocks.
- WAIT_CYCLES, 2500: hold-off after each byte.
- CLR_WAIT, 100000: hold-off after command 0x01.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- start, in, 1: one-cycle request to display.
- opcode, in, 3: CPU opcode.
- result, in, 16: CPU result, two's complement.
- ready, out, 1: idle and able to accept start.
- done, out, 1: one-cycle pulse when display is complete.
- lcd_data, out, 8: HD44780 data bus.
- lcd_rs, out, 1: 0 = command, 1 = data.
- lcd_rw, out, 1: always 0.
- lcd_en, out, 1: enable strobe.

Function
REQ-004 The FSM SHALL use the states PWR_WAIT, INIT, IDLE, CONVERT, WRITE; byte transfers SHALL use the sub-phases SETUP, EN_HI, HOLD.
REQ-005 PWR_WAIT SHALL count POWERUP_CYCLES clocks, then go to INIT.
REQ-006 INIT SHALL issue commands 0x38, 0x0C, 0x06, 0x01 in order, then go to IDLE.
REQ-007 A byte transfer SHALL follow this sequence:
- SETUP: drive lcd_data and lcd_rs, lcd_en=0 for 1 clock.
- EN_HI: lcd_en=1 for EN_CYCLES clocks.
- HOLD: lcd_en=0 with data and rs held for WAIT_CYCLES clocks, or CLR_WAIT if the byte is command 0x01.
REQ-008 ready SHALL be 1 only in IDLE.
REQ-009 start with ready=1 SHALL latch opcode and result on that edge and enter CONVERT on the next clock; start with ready=0 SHALL be ignored and not queued.
REQ-010 CONVERT SHALL behave as follows:
- Magnitude = result if result[15]=0, else (~result+1) taken as 16-bit unsigned, so 0x8000 gives 32768.
- Conversion to 5 BCD digits by double-dabble in exactly 16 clocks, then go to WRITE.
REQ-011 WRITE SHALL send 13 bytes in order:
- cmd 0x01
- cmd 0x80
- 4 mnemonic chars
- cmd 0xC0
- sign char ('+'=0x2B if result[15]=0, else '-'=0x2D)
- 5 ASCII digits, most significant first, leading zeros kept
REQ-012 The mnemonic for each opcode SHALL be: 000 "LOAD", 001 "ADD ", 010 "ADDI", 011 "SUB ", 100 "SUBI", 101 "MUL ", 110 "CLR ", 111 "DPL ", with space = 0x20.
REQ-013 After the HOLD of byte 13, done SHALL pulse for 1 clock and the FSM SHALL go to IDLE in the same cycle.
REQ-014 Latched opcode and result SHALL stay stable through WRITE; input changes after the start edge SHALL have no effect.
REQ-015 Every counter SHALL reload per phase; the width of each counter SHALL hold its largest parameter with no wrap.
REQ-016 lcd_rw SHALL be constant 0.
REQ-017 lcd_data and lcd_rs SHALL change only in SETUP, never while lcd_en=1.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force state to PWR_WAIT and clear all counters;
- drive lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, ready=0, done=0;
- clear latched opcode, result and BCD to 0.
REQ-019 Reset asserted mid-transfer SHALL drop lcd_en in the same cycle; after release the full power-up and init sequence SHALL rerun before ready=1.
REQ-020 The first rising clk edge after rst_n goes high SHALL start the POWERUP_CYCLES count.

Verification
All scenarios use POWERUP_CYCLES=20, EN_CYCLES=2, WAIT_CYCLES=4, CLR_WAIT=8.
REQ-021 Release reset with no start -> bus bytes 0x38, 0x0C, 0x06, 0x01 (rs=0), each with an en pulse 2 clocks wide; ready rises after the 0x01 hold of 8 clocks.
REQ-022 start, opcode=001, result=0x0007 -> bytes 01, 80, 41 44 44 20, C0, 2B 30 30 30 30 37; done pulses once; ready returns to 1.
REQ-023 start, opcode=011, result=0x8000 -> line 2 reads "-32768" (2D 33 32 37 36 38); result=0xFFFF -> "-00001".
REQ-024 start pulsed again during WRITE, and opcode/result changed mid-WRITE -> the second request is ignored and the displayed text matches the first request only.
REQ-025 rst_n asserted while lcd_en=1 during WRITE -> lcd_en=0 with no clock edge; after release, the init bytes reappear and no leftover data bytes are sent.
REQ-026 Checker on every transfer: lcd_data and lcd_rs are stable while lcd_en=1, lcd_rw=0 at all times, and the en-low gap is never shorter than the hold time in REQ-007.
